sr_bank: RTL
============

SR_BANK -- requirements
Module: sr_bank

Interface
REQ-001 Parameter WIDTH, default 4: number of independent set/reset channels, legal range 1..32.
REQ-002 Parameter MODE, default 0: S=R=1 resolution; 0 reset-dominant, 1 set-dominant, 2 toggle.
REQ-003 Parameter DB_CYCLES, default 16: debounce stability window in clock cycles, legal range 2..65535.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 s  input  WIDTH  per-channel set request; asynchronous level, e.g. a manual switch.
REQ-007 r  input  WIDTH  per-channel reset request; asynchronous level.
REQ-008 q  output  WIDTH  registered latch state per channel.
REQ-009 qn  output  WIDTH  complement of q; combinational ~q; q and qn never equal.
REQ-010 rise  output  WIDTH  one-cycle pulse on the cycle after q[i] goes 0->1.
REQ-011 fall  output  WIDTH  one-cycle pulse on the cycle after q[i] goes 1->0.

Function
REQ-012 Each bit of s and r passes through a 2-flop synchronizer; synced value lags input by 2 edges.
REQ-013 Each synced s/r bit has a filtered copy and its own counter, width clog2(DB_CYCLES).
REQ-014 Counter behaviour per bit:
- synced == filtered: counter clears to 0.
- synced != filtered: counter increments.
- counter == DB_CYCLES-1 while still differing: filtered takes synced on that edge and counter clears.
REQ-015 A glitch shorter than DB_CYCLES synced cycles never changes filtered; any return to the filtered value restarts the window.
REQ-016 Latch update per channel from filtered S,R, registered into q:
- S=1,R=0: q=1.
- S=0,R=1: q=0.
- S=0,R=0: hold.
REQ-017 S=1,R=1 with MODE 0: q=0.
REQ-018 S=1,R=1 with MODE 1: q=1.
REQ-019 MODE 2: q inverts once on the cycle the (S&R) condition first becomes true, then holds while both stay high.
REQ-020 MODE 2: q does not toggle again until (S&R) has deasserted and reasserted.
REQ-021 Latency, input change to q change: 2 + DB_CYCLES + 1 edges.
REQ-022 rise and fall are computed against a 1-cycle delayed q.
REQ-023 rise[i] and fall[i] are never both 1; neither pulses when q[i] is unchanged.
REQ-024 Channels are fully independent; simultaneous events on several channels are processed in the same cycle with no interaction.
REQ-025 Out-of-range parameter values stop elaboration through a generate-time check.

Reset
REQ-026 reset_n low immediately forces, without waiting for a clock:
- all synchronizer flops, filtered copies, counters and delayed-q registers to 0.
- q=0, qn=all-ones, rise=0, fall=0.
REQ-027 Reset asserted mid-debounce discards partial counts; after release the debounce window starts from zero.
REQ-028 Release of reset_n is assumed synchronized externally; the first active edge after release evaluates normally.
REQ-029 Inputs held high through reset take effect 2 + DB_CYCLES + 1 edges after release; rise pulses accordingly.

Configuration
REQ-030 Macro SR_BANK_DEBOUNCE_EN defined: the filter stage of REQ-013..REQ-015 is present.
REQ-031 SR_BANK_DEBOUNCE_EN undefined: filter and counters are removed; synced values drive the latch directly.
REQ-032 With SR_BANK_DEBOUNCE_EN undefined, latency is 3 edges and DB_CYCLES is ignored; all other behaviour is unchanged.

Verification
REQ-033 WIDTH=4, DB_CYCLES=4, macro on: s[0] 0->1 held 10 cycles -> q[0]=1 on edge 7, rise[0]=1 on edge 8 only, qn[0]=0.
REQ-034 Same config: s[1] high for 3 synced cycles then low -> q[1] stays 0, no rise/fall pulses, counter returns to 0.
REQ-035 MODE 0: s[2]=r[2]=1 together after q[2]=1 -> q[2]=0 after 7 edges, fall[2] pulses once.
REQ-036 MODE 1 and MODE 2, s=r=4'b1111 from q=4'b0101:
- MODE 1 -> q=4'b1111.
- MODE 2 -> q=4'b1010 exactly once, then stable while held.
REQ-037 Assert reset_n low 2 cycles into a debounce window with s[3]=1 held -> q=0 immediately; after release q[3]=1 only after a full 7 edges.
REQ-038 Macro off, WIDTH=4: r[0] pulse of 1 cycle, aligned with the clock, while q[0]=1 -> q[0]=0 on edge 3, fall[0] on edge 4.

Source files
------------

// File: rtl/sr_bank.sv
`default_nettype none
// ============================================================================
// Module   : sr_bank
// Purpose  : Bank of WIDTH independent set/reset latches with input synchronizers.
//            Optional debounce filter is enabled by defining SR_BANK_DEBOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sr_bank #(
  parameter int WIDTH     = 4,
  parameter int MODE      = 0,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int MODE_RESET_DOM = 0;
  localparam int MODE_SET_DOM   = 1;
  localparam int MODE_TOGGLE    = 2;
  localparam int NB             = 2 * WIDTH;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sr_bank: WIDTH must be in 1..32");
  end
  if (MODE < MODE_RESET_DOM || MODE > MODE_TOGGLE) begin : g_bad_mode
    $error("sr_bank: MODE must be 0, 1 or 2");
  end
  if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_bad_db
    $error("sr_bank: DB_CYCLES must be in 2..65535");
  end

  // Set requests occupy the low half, reset requests the high half.
  logic [NB-1:0]    meta_d, meta_q, sync_d, sync_q;
  logic [NB-1:0]    filt;
  logic [WIDTH-1:0] set_f, rst_f;
  logic [WIDTH-1:0] q_d, q_q, both_d, both_q, q_dly_d, q_dly_q;
  logic [WIDTH-1:0] rise_d, rise_q, fall_d, fall_q;

  always_comb begin
    meta_d = {r, s};
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

`ifdef SR_BANK_DEBOUNCE_EN
  localparam int              CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [NB-1:0]    filt_d, filt_q;
  logic [CNT_W-1:0] cnt_d [NB];
  logic [CNT_W-1:0] cnt_q [NB];

  // Any cycle where synced matches filtered restarts that bit's window.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (sync_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_q;
`endif

  assign set_f = filt[WIDTH-1:0];
  assign rst_f = filt[NB-1:WIDTH];

  always_comb begin
    both_d  = set_f & rst_f;
    q_dly_d = q_q;
    rise_d  = q_q & ~q_dly_q;
    fall_d  = ~q_q & q_dly_q;
    q_d     = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({set_f[i], rst_f[i]})
        2'b10: q_d[i] = 1'b1;
        2'b01: q_d[i] = 1'b0;
        2'b11: begin
          if (MODE == MODE_SET_DOM) begin
            q_d[i] = 1'b1;
          end else if (MODE == MODE_TOGGLE) begin
            // Toggle only on the first cycle both requests are seen together.
            q_d[i] = both_q[i] ? q_q[i] : ~q_q[i];
          end else begin
            q_d[i] = 1'b0;
          end
        end
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q     <= '0;
      both_q  <= '0;
      q_dly_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      q_q     <= q_d;
      both_q  <= both_d;
      q_dly_q <= q_dly_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q    = q_q;
  assign qn   = ~q_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule
`default_nettype wire
